// File: rtl/pipe_defs.sv
// Shared encodings for the pipeline hazard controller: forwarding mux codes,
// controller FSM states and the hard-wired zero register.
package pipe_defs;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    // The younger producer (EX) holds the newer value, so it wins over MEM.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_EXMEM;
        else if (mem_hit)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/haz_match.sv
// Register-number comparator for one source/stage pair; $0 never matches
// because it is never really written.
module haz_match
    import pipe_defs::*;
(
    input  logic [4:0] src,
    input  logic [4:0] dst,
    output logic       hit
);

    assign hit = (dst != REG_ZERO) && (src == dst);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls, flushes,
// PC source and ALU operand forwarding. Define HAZ_FORWARD_EN to enable forwarding.
module pipe_hazard_ctrl
    import pipe_defs::*;
#(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             ex_br_taken,
    input  logic             md_start,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
    logic ld_haz, data_haz;

    haz_match u_rs_ex  (.src(id_rs), .dst(ex_rd),  .hit(rs_ex_hit));
    haz_match u_rt_ex  (.src(id_rt), .dst(ex_rd),  .hit(rt_ex_hit));
    haz_match u_rs_mem (.src(id_rs), .dst(mem_rd), .hit(rs_mem_hit));
    haz_match u_rt_mem (.src(id_rt), .dst(mem_rd), .hit(rt_mem_hit));

    assign ld_haz = ex_memread & ((id_use_rs & rs_ex_hit) | (id_use_rt & rt_ex_hit));

`ifdef HAZ_FORWARD_EN
    assign data_haz = ld_haz;
`else
    // Without bypass paths the consumer waits until the producer has written back.
    assign data_haz = ld_haz
                    | (ex_regwrite  & ((id_use_rs & rs_ex_hit)  | (id_use_rt & rt_ex_hit)))
                    | (mem_regwrite & ((id_use_rs & rs_mem_hit) | (id_use_rt & rt_mem_hit)));
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        pc_src      = 1'b0;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_busy     = 1'b0;

        if (!rst_n) begin
            // Outputs follow reset asynchronously: pipeline frozen and emptied.
            state_nxt  = ST_RUN;
            cnt_nxt    = 4'd0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (md_start) begin
                        state_nxt   = ST_MD_BUSY;
                        cnt_nxt     = 4'(MD_CYCLES - 2);
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_flush = 1'b1;
                    end else if (ex_br_taken) begin
                        // Redirect squashes the wrong-path instructions and any ID stall.
                        pc_src     = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (data_haz) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_flush = 1'b1;
                    md_busy     = 1'b1;
                    if (cnt == 4'd0)
                        state_nxt = ST_RUN;
                    else
                        cnt_nxt = cnt - 4'd1;
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZ_FORWARD_EN
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    assign fwd_a_nxt = fwd_pick(rs_ex_hit & ex_regwrite, rs_mem_hit & mem_regwrite);
    assign fwd_b_nxt = fwd_pick(rt_ex_hit & ex_regwrite, rt_mem_hit & mem_regwrite);

    // Codes travel with the instruction into EX: bubbles carry 00, freezes hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (idex_flush) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (idex_write) begin
            fwd_a_sel <= fwd_a_nxt;
            fwd_b_sel <= fwd_b_nxt;
        end
    end
`else
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!pc_write && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl; expectations follow the
// HAZ_FORWARD_EN setting of the build.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rd, mem_rd;
    logic             id_use_rs, id_use_rt, ex_regwrite, ex_memread;
    logic             mem_regwrite, ex_br_taken, md_start;
    logic             pc_write, pc_src, ifid_write, ifid_flush;
    logic             idex_write, idex_flush, exmem_flush, md_busy;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .ex_br_taken(ex_br_taken), .md_start(md_start),
        .pc_write(pc_write), .pc_src(pc_src),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n)
            assert (!(md_start && ex_br_taken))
                else $error("illegal md_start with ex_br_taken");

    typedef enum { K_NORM, K_STALL, K_BR, K_FRZ, K_BUSY, K_RST } kind_t;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] ex_rd;
        logic       ex_rw, ex_mr;
        logic [4:0] mem_rd;
        logic       mem_rw, br;
        kind_t      k_fwd, k_nofwd;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t tbl[13];

    int n_checks = 0;
    int n_pass   = 0;

    logic [CNT_W-1:0] exp_stall = '0;
    logic [1:0]       exp_fa = 2'b00, exp_fb = 2'b00;

    // {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush, md_busy}
    function automatic logic [7:0] ctl_of(input kind_t k);
        case (k)
            K_NORM:  return 8'b1010_1000;
            K_STALL: return 8'b0000_1100;
            K_BR:    return 8'b1111_1100;
            K_FRZ:   return 8'b0000_0010;
            K_BUSY:  return 8'b0000_0011;
            default: return 8'b0001_0100;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        id_rs = v.rs;  id_rt = v.rt;  id_use_rs = v.urs;  id_use_rt = v.urt;
        ex_rd = v.ex_rd;  ex_regwrite = v.ex_rw;  ex_memread = v.ex_mr;
        mem_rd = v.mem_rd;  mem_regwrite = v.mem_rw;  ex_br_taken = v.br;
    endtask

    task automatic drive_idle();
        vec_t v;
        v = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
              K_NORM, K_NORM, 2'b00, 2'b00};
        drive(v);
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic step(input string name, input kind_t k, input logic [1:0] fa,
                        input logic [1:0] fb);
        logic [7:0] exp_ctl;
        exp_ctl = ctl_of(k);
        #1;
        check({name, ".ctl"}, {8'h00, pc_write, pc_src, ifid_write, ifid_flush,
              idex_write, idex_flush, exmem_flush, md_busy}, {8'h00, exp_ctl});
        @(posedge clk);
        #1;
        if (!exp_ctl[7] && exp_stall != '1)
            exp_stall = exp_stall + 1'b1;
        case (k)
            K_NORM:       begin exp_fa = fa;    exp_fb = fb;    end
            K_STALL, K_BR: begin exp_fa = 2'b00; exp_fb = 2'b00; end
            default:      ;
        endcase
        check({name, ".fwd_a"}, 16'(fwd_a_sel), 16'(exp_fa));
        check({name, ".fwd_b"}, 16'(fwd_b_sel), 16'(exp_fb));
        check({name, ".stall_cnt"}, 16'(stall_cnt), 16'(exp_stall));
        @(negedge clk);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        drive(v);
`ifdef HAZ_FORWARD_EN
        step(name, v.k_fwd, v.fa, v.fb);
`else
        step(name, v.k_nofwd, 2'b00, 2'b00);
`endif
    endtask

    initial begin
        //        rs     rt     urs   urt   ex_rd  ex_rw ex_mr mem_rd mem_rw br    fwd      nofwd    fa     fb
        tbl[0]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, K_NORM,  K_STALL, 2'b10, 2'b00};
        tbl[1]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, K_NORM,  K_STALL, 2'b10, 2'b00};
        tbl[2]  = '{5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, K_NORM,  K_NORM,  2'b00, 2'b00};
        tbl[3]  = '{5'd0,  5'd7,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 5'd7,  1'b1, 1'b0, K_NORM,  K_STALL, 2'b00, 2'b01};
        tbl[4]  = '{5'd3,  5'd0,  1'b1, 1'b0, 5'd3,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, K_NORM,  K_NORM,  2'b00, 2'b00};
        tbl[5]  = '{5'd4,  5'd6,  1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 5'd6,  1'b1, 1'b0, K_NORM,  K_STALL, 2'b10, 2'b01};
        tbl[6]  = '{5'd0,  5'd8,  1'b0, 1'b1, 5'd8,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, K_STALL, K_STALL, 2'b00, 2'b00};
        tbl[7]  = '{5'd0,  5'd8,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 5'd8,  1'b1, 1'b0, K_NORM,  K_STALL, 2'b00, 2'b01};
        tbl[8]  = '{5'd0,  5'd8,  1'b0, 1'b1, 5'd8,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, K_BR,    K_BR,    2'b00, 2'b00};
        tbl[9]  = '{5'd9,  5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd9,  1'b1, 1'b0, K_NORM,  K_STALL, 2'b01, 2'b00};
        tbl[10] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, K_BR,    K_BR,    2'b00, 2'b00};
        tbl[11] = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 5'd4,  1'b1, 1'b0, K_NORM,  K_NORM,  2'b00, 2'b00};
        tbl[12] = '{5'd10, 5'd10, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, K_NORM,  K_STALL, 2'b10, 2'b10};

        rst_n = 1'b0;
        md_start = 1'b0;
        drive_idle();
        #3;
        check("reset.ctl", {8'h00, pc_write, pc_src, ifid_write, ifid_flush, idex_write,
              idex_flush, exmem_flush, md_busy}, {8'h00, ctl_of(K_RST)});
        check("reset.fwd_a", 16'(fwd_a_sel), 16'd0);
        check("reset.stall_cnt", 16'(stall_cnt), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_vec($sformatf("vec%0d", i), tbl[i]);

        // Mult/div: operands set up to match, branch raised while busy must be ignored.
        drive(tbl[0]);
        md_start = 1'b1;
        step("md_start", K_FRZ, 2'b00, 2'b00);
        md_start = 1'b0;
        ex_br_taken = 1'b1;
        for (int c = 0; c < 3; c++)
            step($sformatf("md_busy%0d", c), K_BUSY, 2'b00, 2'b00);
        drive_idle();
        step("md_done", K_NORM, 2'b00, 2'b00);

        // Reset landing in the second busy cycle.
        md_start = 1'b1;
        step("md2_start", K_FRZ, 2'b00, 2'b00);
        md_start = 1'b0;
        step("md2_busy0", K_BUSY, 2'b00, 2'b00);
        rst_n = 1'b0;
        #1;
        exp_stall = '0;
        exp_fa = 2'b00;
        exp_fb = 2'b00;
        check("md_rst.ctl", {8'h00, pc_write, pc_src, ifid_write, ifid_flush, idex_write,
              idex_flush, exmem_flush, md_busy}, {8'h00, ctl_of(K_RST)});
        check("md_rst.stall_cnt", 16'(stall_cnt), 16'd0);
        check("md_rst.fwd_a", 16'(fwd_a_sel), 16'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        step("md_rst.run", K_NORM, 2'b00, 2'b00);

        // Held load-use stall drives the counter into saturation.
        drive(tbl[6]);
        for (int c = 0; c < 20; c++)
            step($sformatf("sat%0d", c), K_STALL, 2'b00, 2'b00);
        check("sat.final", 16'(stall_cnt), 16'hF);
        drive_idle();
        step("sat.release", K_NORM, 2'b00, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
